// File: rtl/fft_out_serializer_if.sv
// Bundle of the four-lane FFT input group and the serial output stream.
//
// Handshake: o_valid/i_ready follow strict valid/ready rules. A sample moves
// on a rising edge where o_valid=1 and i_ready=1. Once o_valid is high it
// stays high, and o_data/o_lane/o_sof hold stable, until that transfer
// happens. o_valid never depends combinationally on i_ready or in_enable.
// The input side has no ready: the block accepts a group whenever in_enable=1
// and drops it (sticky o_overflow) when the buffer is full.
interface fft_out_serializer_if #(
  parameter int NBITS_out = 10,
  parameter int DEPTH     = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [2*NBITS_out-1:0] fftIn0_up;
  logic [2*NBITS_out-1:0] fftIn0_down;
  logic [2*NBITS_out-1:0] fftIn1_up;
  logic [2*NBITS_out-1:0] fftIn1_down;
  logic                   in_enable;
  logic [2*NBITS_out-1:0] o_data;
  logic                   o_valid;
  logic                   i_ready;
  logic [1:0]             o_lane;
  logic                   o_sof;
  logic                   o_overflow;
  logic [LW-1:0]          o_level;

  // Producer of groups and consumer of the serial stream
  modport master (
    output fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, in_enable, i_ready,
    input  o_data, o_valid, o_lane, o_sof, o_overflow, o_level
  );

  // The serializer itself
  modport slave (
    input  fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, in_enable, i_ready,
    output o_data, o_valid, o_lane, o_sof, o_overflow, o_level
  );
endinterface

// File: rtl/fft_out_serializer.sv
// Buffers 4-lane FFT output groups and emits them one sample per transfer,
// lane order 0..3, with a start-of-frame tag on point 0 of each frame.
module fft_out_serializer #(
  parameter int NBITS_out = 10,
  parameter int N         = 128,
  parameter int DEPTH     = 8
) (
  input logic               clk,
  input logic               rst,
  fft_out_serializer_if.slave bus
);
  localparam int W  = 2 * NBITS_out;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int GW = (N / 4 > 1) ? $clog2(N / 4) : 1;

  typedef struct packed {
    logic         sof;
    logic [W-1:0] l3;
    logic [W-1:0] l2;
    logic [W-1:0] l1;
    logic [W-1:0] l0;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [1:0]     lane_q, lane_d;
  logic [GW-1:0]  grp_q, grp_d;
  logic           ovf_q, ovf_d;

  logic           valid;
  logic           full;
  logic           push;
  logic           xfer;
  logic           retire;
  entry_t         head;
  logic [W-1:0]   lane_data;

  // Next-state: fullness judged on the registered level, so a pop in the
  // same cycle never makes room for the incoming group.
  always_comb begin
    valid    = (level_q != '0);
    full     = (level_q == LW'(DEPTH));
    push     = bus.in_enable && !full;
    xfer     = valid && bus.i_ready;
    retire   = xfer && (lane_q == 2'd3);

    wr_ptr_d = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = retire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    lane_d   = xfer   ? lane_q + 2'd1   : lane_q;
    ovf_d    = ovf_q || (bus.in_enable && full);

    level_d  = level_q;
    case ({push, retire})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    grp_d = grp_q;
    if (bus.in_enable) begin
      grp_d = (grp_q == GW'(N / 4 - 1)) ? '0 : grp_q + 1'b1;
    end
  end

  // Control registers; reset wins over every input in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      lane_q   <= 2'd0;
      grp_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      lane_q   <= lane_d;
      grp_q    <= grp_d;
      ovf_q    <= ovf_d;
    end
  end

  // Group storage; entries are only read while counted in level, so no reset
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= '{sof: (grp_q == '0),
                           l3:  bus.fftIn1_down,
                           l2:  bus.fftIn1_up,
                           l1:  bus.fftIn0_down,
                           l0:  bus.fftIn0_up};
    end
  end

  // Output mux: head entry, lane selected by the registered lane index
  always_comb begin
    head = mem_q[rd_ptr_q];
    case (lane_q)
      2'd0:    lane_data = head.l0;
      2'd1:    lane_data = head.l1;
      2'd2:    lane_data = head.l2;
      default: lane_data = head.l3;
    endcase
    bus.o_data     = valid ? lane_data : '0;
    bus.o_valid    = valid;
    bus.o_lane     = lane_q;
    bus.o_sof      = valid && (lane_q == 2'd0) && head.sof;
    bus.o_overflow = ovf_q;
    bus.o_level    = level_q;
  end
endmodule

// File: doc/fft_out_serializer.md
FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 Parameter NBITS_out, default 10: width of each real/imaginary part of a lane sample.
REQ-002 Parameter N, default 128: FFT frame length in points; N/4 groups per frame.
REQ-003 Parameter DEPTH, default 8: group-buffer capacity in 4-lane groups (power of 2, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 fftIn0_up  input  NBITS_out*2  lane 0 sample; upper half imaginary, lower half real.
REQ-007 fftIn0_down  input  NBITS_out*2  lane 1 sample; same packing.
REQ-008 fftIn1_up  input  NBITS_out*2  lane 2 sample; same packing.
REQ-009 fftIn1_down  input  NBITS_out*2  lane 3 sample; same packing.
REQ-010 in_enable  input  1  the four lanes carry one valid group this cycle.
REQ-011 o_data  output  NBITS_out*2  serial output sample, same packing.
REQ-012 o_valid  output  1  o_data holds a valid sample.
REQ-013 i_ready  input  1  downstream accepts o_data this cycle.
REQ-014 o_lane  output  2  source lane index of o_data (0..3).
REQ-015 o_sof  output  1  o_data is point 0 of a frame.
REQ-016 o_overflow  output  1  sticky: at least one group dropped since reset.
REQ-017 o_level  output  clog2(DEPTH)+1  number of groups held, including the group currently being serialized.

Function
REQ-018 Each cycle with in_enable=1 and level<DEPTH, the block shall write all four lanes plus an sof tag into the buffer as one entry.
REQ-019 Fullness shall be judged on the registered level at the start of the cycle; with level=DEPTH, an in_enable group shall be dropped even if a pop occurs in the same cycle.
REQ-020 A dropped group shall set o_overflow to 1 until reset; no other state shall change except the input group counter.
REQ-021 The input group counter shall advance on every in_enable (stored or dropped), wrap from N/4-1 to 0, and tag the stored entry sof=1 when its value is 0.
REQ-022 The read side shall emit lanes of the head entry in order 0,1,2,3 (fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down), one per accepted transfer.
REQ-023 A transfer shall occur when o_valid=1 and i_ready=1; o_lane shall then advance, wrapping 3->0 and retiring the entry.
REQ-024 While o_valid=1 and i_ready=0, o_data, o_lane and o_sof shall hold stable.
REQ-025 o_valid shall be 1 exactly when level>=1.
REQ-026 Latency: a group written into an empty buffer at edge k shall present lane 0 with o_valid=1 from edge k onward; o_valid never asserts combinationally from in_enable.
REQ-027 o_sof shall be 1 only for o_lane=0 of an entry tagged sof.
REQ-028 A simultaneous write and retire shall leave level unchanged; write without retire: level+1; retire without write: level-1.
REQ-029 With i_ready held at 1, sustained throughput shall be one sample per cycle; since input supplies four per group, in_enable duty above 25% shall eventually fill the buffer.
REQ-030 Pointers shall wrap modulo DEPTH without a bubble.

Reset
REQ-031 When rst=1 at a rising edge: o_valid=0, o_lane=0, o_sof=0, o_overflow=0, o_level=0, o_data=0, read/write pointers=0, input group counter=0.
REQ-032 Reset shall take priority over in_enable and i_ready in the same cycle; a group presented during reset shall be discarded.
REQ-033 Reset mid-frame shall discard all buffered data; the first in_enable after reset shall be tagged sof=1.

Verification
REQ-034 Single group: after reset, lanes 0x00001,0x00002,0x00003,0x00004 with in_enable one cycle, i_ready=1 -> four consecutive outputs 1,2,3,4, o_lane 0..3, o_sof=1 on first only, then o_valid=0.
REQ-035 Backpressure: i_ready=0 for 5 cycles while o_valid=1 -> o_data/o_lane/o_sof constant; on release the sequence resumes without loss or duplication.
REQ-036 Overflow: i_ready=0, in_enable for DEPTH+2 groups -> o_level=DEPTH, o_overflow=1; draining yields exactly the first DEPTH groups, in order.
REQ-037 Full plus simultaneous pop: level=DEPTH, retire on lane 3 and in_enable in the same cycle -> group dropped, o_overflow=1, level=DEPTH-1.
REQ-038 Frame tagging: 64 consecutive groups with default N, i_ready=1, in_enable 25% duty -> o_sof=1 on serial outputs 0 and 128 only.
REQ-039 Reset mid-operation: rst for one cycle with 3 groups buffered -> next cycle o_valid=0, o_level=0; the next group emits with o_sof=1.
